// File: rtl/pixel_pipe_pkg.sv
// Shared types for the pixel pipeline: mode word layout, channel permutation
// codes, the delayed timing tag and the 2x2 ordered-dither threshold table.
package pixel_pipe_pkg;

    typedef enum logic [2:0] {
        PERM_RGB = 3'd0,
        PERM_RBG = 3'd1,
        PERM_GRB = 3'd2,
        PERM_GBR = 3'd3,
        PERM_BRG = 3'd4,
        PERM_BGR = 3'd5
    } perm_e;

    // inv[0] inverts the red output channel, inv[2] the blue one.
    typedef struct packed {
        logic [2:0] inv;
        perm_e      perm;
        logic       gray;
        logic       dither;
    } mode_t;

    // Only what later stages need from the raster position travels down the pipe.
    typedef struct packed {
        logic vis;
        logic hpar;
        logic vpar;
        logic hs;
        logic vs;
    } tag_t;

    localparam logic [1:0] BAYER [4] = '{2'd0, 2'd2, 2'd3, 2'd1};

endpackage

// File: rtl/pixel_dither.sv
// Ordered-dither adder: adds a position-dependent threshold to each channel
// and clamps to full scale instead of wrapping.
module pixel_dither
    import pixel_pipe_pkg::*;
#(
    parameter int CH_W  = 8,
    parameter int OUT_W = 4
) (
    input  logic [3*CH_W-1:0] data_i,
    input  logic              en_i,
    input  logic [1:0]        phase_i,
    output logic [3*CH_W-1:0] data_o
);

    localparam int SHIFT = CH_W - OUT_W - 2;

    logic [CH_W-1:0] thr;

    assign thr = en_i ? (CH_W'(BAYER[phase_i]) << SHIFT) : '0;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            logic [CH_W:0] sum;
            assign sum = {1'b0, data_i[gi*CH_W +: CH_W]} + {1'b0, thr};
            assign data_o[gi*CH_W +: CH_W] = sum[CH_W] ? {CH_W{1'b1}} : sum[CH_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/pixel_proc_pipe.sv
// Frame-buffer to VGA pixel pipeline: address generation, then dither, gray,
// channel scramble and output quantisation, with syncs delayed to match.
module pixel_proc_pipe
    import pixel_pipe_pkg::*;
#(
    parameter int CH_W       = 8,
    parameter int OUT_W      = 4,
    parameter int CNT_W      = 11,
    parameter int ADDR_W     = 18,
    parameter int IMG_W_LOG2 = 9,
    parameter int SCALE_LOG2 = 1,
    parameter int MEM_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CNT_W-1:0]     hc_visible,
    input  logic [CNT_W-1:0]     vc_visible,
    input  logic                 hs_in,
    input  logic                 vs_in,
    input  logic [7:0]           mode_in,
    output logic                 mem_en,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [3*CH_W-1:0]    mem_data,
    output logic [OUT_W-1:0]     vga_r,
    output logic [OUT_W-1:0]     vga_g,
    output logic [OUT_W-1:0]     vga_b,
    output logic                 vga_hs,
    output logic                 vga_vs,
    output logic                 frame_start
);

    localparam int DLY = MEM_LAT + 4;

    typedef logic [2:0][CH_W-1:0] px_t;   // [2]=R, [1]=G, [0]=B

    logic [CNT_W-1:0]  hx, vy;
    logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
    logic              mem_en_q;
    tag_t              tag_d;
    tag_t              tag_q [DLY];
    mode_t             mode_q;
    logic              vs_prev_q, frame_start_q, vs_fall;
    logic              g_blank_q, s_blank_q;
    logic [3*CH_W-1:0] dith_d;
    px_t               d_q, g_d, g_q, s_d, s_q;
    logic [CH_W+1:0]   gray_sum;
    logic [CH_W-1:0]   gray_avg;
    logic [OUT_W-1:0]  vga_r_q, vga_g_q, vga_b_q;
    logic              vga_hs_q, vga_vs_q;

    assign hx         = (hc_visible - CNT_W'(1)) >> SCALE_LOG2;
    assign vy         = (vc_visible - CNT_W'(1)) >> SCALE_LOG2;
    assign mem_addr_d = ADDR_W'(hx) + (ADDR_W'(vy) << IMG_W_LOG2);

    assign tag_d.vis  = (hc_visible != '0) && (vc_visible != '0);
    assign tag_d.hpar = hc_visible[0];
    assign tag_d.vpar = vc_visible[0];
    assign tag_d.hs   = hs_in;
    assign tag_d.vs   = vs_in;

    assign vs_fall = vs_prev_q & ~vs_in;

    pixel_dither #(.CH_W(CH_W), .OUT_W(OUT_W)) u_dither (
        .data_i  (mem_data),
        .en_i    (mode_q.dither),
        .phase_i ({tag_q[MEM_LAT].vpar, tag_q[MEM_LAT].hpar}),
        .data_o  (dith_d)
    );

    always_comb begin
        gray_sum = (CH_W+2)'(d_q[2]) + (CH_W+2)'(d_q[1]) + (CH_W+2)'(d_q[0]);
        gray_avg = CH_W'(gray_sum / (CH_W+2)'(3));
        g_d      = mode_q.gray ? {3{gray_avg}} : d_q;
    end

    always_comb begin
        s_d = '0;
        case (mode_q.perm)
            PERM_RGB: s_d = {g_q[2], g_q[1], g_q[0]};
            PERM_RBG: s_d = {g_q[2], g_q[0], g_q[1]};
            PERM_GRB: s_d = {g_q[1], g_q[2], g_q[0]};
            PERM_GBR: s_d = {g_q[1], g_q[0], g_q[2]};
            PERM_BRG: s_d = {g_q[0], g_q[2], g_q[1]};
            PERM_BGR: s_d = {g_q[0], g_q[1], g_q[2]};
            default:  s_d = '0;
        endcase
        for (int i = 0; i < 3; i++) begin
            if (mode_q.inv[2-i]) s_d[i] = ~s_d[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en_q      <= 1'b0;
            mem_addr_q    <= '0;
            for (int i = 0; i < DLY; i++) tag_q[i] <= '0;
            vs_prev_q     <= 1'b0;
            frame_start_q <= 1'b0;
            mode_q        <= '0;
            d_q           <= '0;
            g_q           <= '0;
            s_q           <= '0;
            g_blank_q     <= 1'b0;
            s_blank_q     <= 1'b0;
            vga_r_q       <= '0;
            vga_g_q       <= '0;
            vga_b_q       <= '0;
            vga_hs_q      <= 1'b0;
            vga_vs_q      <= 1'b0;
        end else begin
            mem_en_q   <= tag_d.vis;
            mem_addr_q <= mem_addr_d;
            tag_q[0]   <= tag_d;
            for (int i = 1; i < DLY; i++) tag_q[i] <= tag_q[i-1];

            vs_prev_q     <= vs_in;
            frame_start_q <= vs_fall;
            if (vs_fall) mode_q <= mode_t'(mode_in);

            d_q <= dith_d;
            g_q <= g_d;
            s_q <= s_d;
            // Pixels sitting in D or G when the mode flips saw both modes; suppress them.
            g_blank_q <= frame_start_q;
            s_blank_q <= g_blank_q | frame_start_q;

            if (tag_q[DLY-1].vis && !s_blank_q) begin
                vga_r_q <= s_q[2][CH_W-1 -: OUT_W];
                vga_g_q <= s_q[1][CH_W-1 -: OUT_W];
                vga_b_q <= s_q[0][CH_W-1 -: OUT_W];
            end else begin
                vga_r_q <= '0;
                vga_g_q <= '0;
                vga_b_q <= '0;
            end
            vga_hs_q <= tag_q[DLY-1].hs;
            vga_vs_q <= tag_q[DLY-1].vs;
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_addr    = mem_addr_q;
    assign frame_start = frame_start_q;
    assign vga_r       = vga_r_q;
    assign vga_g       = vga_g_q;
    assign vga_b       = vga_b_q;
    assign vga_hs      = vga_hs_q;
    assign vga_vs      = vga_vs_q;

endmodule

// File: tb/tb_pixel_proc_pipe.sv
// Randomised bench for pixel_proc_pipe against a cycle-indexed behavioural
// model of the raster, mode timeline and per-pixel colour transform.
module tb_pixel_proc_pipe;

    localparam int CH_W    = 8;
    localparam int OUT_W   = 4;
    localparam int CNT_W   = 11;
    localparam int ADDR_W  = 18;
    localparam int MEM_LAT = 2;
    localparam int LAT     = MEM_LAT + 5;
    localparam int N       = 800;

    localparam int BAYER_T [4]     = '{0, 2, 3, 1};
    localparam int PERM_SRC [6][3] = '{'{0,1,2}, '{0,2,1}, '{1,0,2}, '{1,2,0}, '{2,0,1}, '{2,1,0}};

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [CNT_W-1:0]    hc_visible, vc_visible;
    logic                hs_in, vs_in;
    logic [7:0]          mode_in;
    logic                mem_en;
    logic [ADDR_W-1:0]   mem_addr;
    logic [3*CH_W-1:0]   mem_data;
    logic [OUT_W-1:0]    vga_r, vga_g, vga_b;
    logic                vga_hs, vga_vs, frame_start;

    always #5 clk = ~clk;

    pixel_proc_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hc_visible  (hc_visible),
        .vc_visible  (vc_visible),
        .hs_in       (hs_in),
        .vs_in       (vs_in),
        .mode_in     (mode_in),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .frame_start (frame_start)
    );

    int        hc_a [N];
    int        vc_a [N];
    bit        hs_a [N];
    bit        vs_a [N];
    bit [7:0]  md_a [N];
    bit [23:0] px_a [N];
    bit        fs_a [N];
    bit [7:0]  am_a [N];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Before the first sampled cycle the DUT has seen reset (syncs low), then the idle cycle (syncs high).
    function automatic int vs_at(int k);
        if (k <= -2) return 0;
        if (k == -1) return 1;
        return int'(vs_a[k]);
    endfunction

    function automatic int hs_at(int k);
        if (k <= -2) return 0;
        if (k == -1) return 1;
        return int'(hs_a[k]);
    endfunction

    function automatic int exp_addr(int hc, int vc);
        int h, v;
        h = (hc + 2047) % 2048;
        v = (vc + 2047) % 2048;
        return ((h / 2) + (v / 2) * 512) % 262144;
    endfunction

    function automatic logic [11:0] model_pix(bit [23:0] px, bit [7:0] m, int hc, int vc);
        int ch [3];
        int o  [3];
        int thr, p;
        ch[0] = int'(px[23:16]);
        ch[1] = int'(px[15:8]);
        ch[2] = int'(px[7:0]);
        if (m[0]) begin
            thr = BAYER_T[(vc % 2) * 2 + (hc % 2)] * 4;
            for (int i = 0; i < 3; i++) ch[i] = (ch[i] + thr > 255) ? 255 : ch[i] + thr;
        end
        if (m[1]) begin
            thr = (ch[0] + ch[1] + ch[2]) / 3;
            for (int i = 0; i < 3; i++) ch[i] = thr;
        end
        p = int'(m[4:2]);
        for (int i = 0; i < 3; i++) begin
            o[i] = (p < 6) ? ch[PERM_SRC[p][i]] : 0;
            if (m[5 + i]) o[i] = 255 - o[i];
        end
        return {4'(o[0] / 16), 4'(o[1] / 16), 4'(o[2] / 16)};
    endfunction

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_mem_en"}, 32'(mem_en), 0);
        check_eq({pfx, "_mem_addr"}, 32'(mem_addr), 0);
        check_eq({pfx, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 0);
        check_eq({pfx, "_syncs"}, 32'({vga_hs, vga_vs}), 0);
        check_eq({pfx, "_frame_start"}, 32'(frame_start), 0);
    endtask

    initial begin
        bit [7:0] cur;
        bit       fall;
        int       t, r, hcx, vcx;
        logic [11:0] exp_px;

        for (int c = 0; c < N; c++) begin
            hc_a[c] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 2047));
            vc_a[c] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 2047));
            hs_a[c] = ($urandom_range(0, 3) != 0);
            vs_a[c] = !(c >= 60 && (c % 60) < 3);
            md_a[c] = 8'($urandom_range(0, 255));
            for (int k = 0; k < 3; k++) begin
                r = int'($urandom_range(0, 7));
                px_a[c][k*8 +: 8] = (r == 0) ? 8'hFF : (r == 1) ? 8'h0E : 8'($urandom_range(0, 255));
            end
        end
        hc_a[0] = 1;    vc_a[0] = 1;
        hc_a[1] = 1024; vc_a[1] = 768;
        hc_a[2] = 3;    vc_a[2] = 2;   px_a[2]  = 24'hA53CF0;
        hc_a[3] = 0;    vc_a[3] = 2;   px_a[3]  = 24'hA53CF0;
        vs_a[20] = 1'b0; md_a[20] = 8'h01;
        hc_a[25] = 1;   vc_a[25] = 2;  px_a[25] = 24'h0E0E0E;
        hc_a[26] = 2;   vc_a[26] = 3;  px_a[26] = 24'hFFFFFF;
        vs_a[34] = 1'b0; md_a[34] = 8'h02;
        hc_a[38] = 5;   vc_a[38] = 5;  px_a[38] = 24'hFF0001;
        vs_a[46] = 1'b0; md_a[46] = 8'h94;
        hc_a[50] = 7;   vc_a[50] = 9;  px_a[50] = 24'h102030;

        // Mode in force during each cycle, and the cycles that open a new mode.
        cur = 8'h00;
        for (int c = 0; c < N; c++) begin
            fall = (vs_at(c - 2) == 1) && (vs_at(c - 1) == 0);
            if (fall) cur = md_a[c - 1];
            fs_a[c] = fall;
            am_a[c] = cur;
        end

        hc_visible = 11'd5; vc_visible = 11'd5; hs_in = 1'b0; vs_in = 1'b1;
        mode_in = 8'hFF; mem_data = 24'hFFFFFF;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        vs_in = 1'b0;
        @(negedge clk);
        check_all_zero("reset2");

        hc_visible = '0; vc_visible = '0; hs_in = 1'b1; vs_in = 1'b1;
        mode_in = 8'h00; mem_data = '0;
        rst_n = 1'b1;

        for (int c = 0; c < N; c++) begin
            @(posedge clk);
            #1;
            hc_visible = CNT_W'(hc_a[c]);
            vc_visible = CNT_W'(vc_a[c]);
            hs_in      = hs_a[c];
            vs_in      = vs_a[c];
            mode_in    = md_a[c];
            mem_data   = (c >= MEM_LAT + 1) ? px_a[c - MEM_LAT - 1] : 24'h0;
            @(negedge clk);

            hcx = (c >= 1) ? hc_a[c - 1] : 0;
            vcx = (c >= 1) ? vc_a[c - 1] : 0;
            check_eq("mem_en", 32'(mem_en), 32'(hcx != 0 && vcx != 0));
            check_eq("mem_addr", 32'(mem_addr), 32'(exp_addr(hcx, vcx)));
            check_eq("frame_start", 32'(frame_start), 32'(fs_a[c]));

            t = c - LAT;
            check_eq("vga_hs", 32'(vga_hs), 32'(hs_at(t)));
            check_eq("vga_vs", 32'(vga_vs), 32'(vs_at(t)));
            exp_px = '0;
            if (t >= 0 && hc_a[t] != 0 && vc_a[t] != 0 && !fs_a[c - 3] && !fs_a[c - 2])
                exp_px = model_pix(px_a[t], am_a[c - 2], hc_a[t], vc_a[t]);
            check_eq("vga_r", 32'(vga_r), 32'(exp_px[11:8]));
            check_eq("vga_g", 32'(vga_g), 32'(exp_px[7:4]));
            check_eq("vga_b", 32'(vga_b), 32'(exp_px[3:0]));

            case (c)
                1:  begin
                        check_eq("first_en", 32'(mem_en), 1);
                        check_eq("first_addr", 32'(mem_addr), 0);
                    end
                2:  check_eq("corner_addr", 32'(mem_addr), 196607);
                9:  check_eq("plain_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0A3F);
                10: check_eq("blank_rgb", 32'({vga_r, vga_g, vga_b}), 0);
                21: check_eq("fs_pulse", 32'(frame_start), 1);
                22: check_eq("fs_end", 32'(frame_start), 0);
                32: check_eq("dither_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0111);
                33: check_eq("dither_sat", 32'({vga_r, vga_g, vga_b}), 32'h0FFF);
                45: check_eq("gray_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0555);
                57: check_eq("perm_inv_rgb", 32'({vga_r, vga_g, vga_b}), 32'h032E);
                default: ;
            endcase
        end

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
